// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared types and constants for the test pass/fail/timeout
// monitor.
//   state_t : monitor FSM states
//   mode_t  : end-of-test convention selector (mode_i encoding)
package test_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_TOHOST = 2'd0,
    MODE_TRAP   = 2'd1,
    MODE_BOTH   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // a7 value of the exit syscall used by the riscv-tests ECALL sequence
  localparam logic [31:0] SYS_EXIT              = 32'd93;
  localparam logic [31:0] FAIL_CODE_UNSUPPORTED = 32'hFFFF_FFFF;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : increment request
//   q_o          : count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/test_monitor.sv
// test_monitor: snoops the data-memory write port and writeback trap state of
// the core and decides pass/fail/timeout of a riscv-test or compliance test.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   en_i                   : arm; low forces IDLE and clears every output
//   mode_i                 : 0 tohost, 1 trap, 2/3 both
//   dmem_*_i               : data-memory write snoop
//   trap_i, gp_i/a7_i/a0_i : retiring trap and x3/x17/x10
//   sig_begin_i/sig_end_i  : signature region [begin, end)
//   done_o/pass_o/fail_o/timeout_o, fail_code_o : registered outcome
//   cycles_o, sig_writes_o : RUN cycle count, signature-region write count
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned MAX_TICKS   = 100000,
  parameter int          CNT_W       = 32,
  parameter int          SIG_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [1:0]           mode_i,
  input  logic [31:0]          dmem_addr_i,
  input  logic [3:0]           dmem_wsel_byte_i,
  input  logic [31:0]          dmem_wdata_i,
  input  logic                 trap_i,
  input  logic [31:0]          gp_i,
  input  logic [31:0]          a7_i,
  input  logic [31:0]          a0_i,
  input  logic [31:0]          sig_begin_i,
  input  logic [31:0]          sig_end_i,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [31:0]          fail_code_o,
  output logic [CNT_W-1:0]     cycles_o,
  output logic [SIG_CNT_W-1:0] sig_writes_o
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(MAX_TICKS - 1);

  state_t      state_q;
  logic        done_q, pass_q, fail_q, timeout_q;
  logic [31:0] fail_code_q;

  logic        tohost_en, trap_en;
  logic        tohost_hit, trap_hit;
  logic        res_valid, res_pass;
  logic [31:0] res_code;
  logic        run_cyc, cnt_clr, sig_inc, timeout_hit;

  // Reserved mode 3 behaves as BOTH.
  assign tohost_en = (mode_i != MODE_TRAP);
  assign trap_en   = (mode_i != MODE_TOHOST);

  // A zero write to tohost is the test clearing the mailbox, not a result.
  assign tohost_hit = tohost_en && (dmem_wsel_byte_i == 4'hF) &&
                      (dmem_addr_i[31:2] == TOHOST_ADDR[31:2]) &&
                      (dmem_wdata_i != 32'd0);
  assign trap_hit   = trap_en && trap_i && (a7_i == SYS_EXIT);

  // Result decode; tohost takes priority over a simultaneous trap.
  always_comb begin
    res_valid = 1'b0;
    res_pass  = 1'b0;
    res_code  = 32'd0;
    if (tohost_hit) begin
      res_valid = 1'b1;
      if (dmem_wdata_i == 32'd1) begin
        res_pass = 1'b1;
      end else if (dmem_wdata_i[0]) begin
        res_code = {1'b0, dmem_wdata_i[31:1]};
      end else begin
        res_code = FAIL_CODE_UNSUPPORTED;
      end
    end else if (trap_hit) begin
      if (a0_i != 32'd0) begin
        res_valid = 1'b1;
        res_code  = {1'b0, a0_i[31:1]};
      end else if (gp_i == 32'd1) begin
        res_valid = 1'b1;
        res_pass  = 1'b1;
      end
    end
  end

  assign run_cyc     = en_i && (state_q == RUN);
  assign cnt_clr     = !en_i || (state_q == IDLE);
  assign timeout_hit = (cycles_o == LAST_TICK);
  assign sig_inc     = run_cyc && (dmem_wsel_byte_i != 4'h0) &&
                       (dmem_addr_i >= sig_begin_i) && (dmem_addr_i < sig_end_i);

  // The transition edge out of RUN still counts, so cycles_o reads MAX_TICKS
  // on timeout and (event cycle + 1) on a decoded result.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (run_cyc),
    .q_o   (cycles_o)
  );

  sat_counter #(.W(SIG_CNT_W)) u_sig_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .inc_i (sig_inc),
    .q_o   (sig_writes_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: begin
          if (res_valid) begin
            state_q     <= res_pass ? PASS : FAIL;
            done_q      <= 1'b1;
            pass_q      <= res_pass;
            fail_q      <= !res_pass;
            fail_code_q <= res_code;
          end else if (timeout_hit) begin
            state_q   <= TIMEOUT;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign fail_code_o = fail_code_q;

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;

  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam logic [31:0] SIG_B  = 32'h8000_2000;
  localparam logic [31:0] SIG_E  = 32'h8000_2010;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [31:0] addr, wdata, gp, a7, a0, sig_b, sig_e;
  logic [3:0]  wsel;
  logic        trap;

  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] fail_code_o, cycles_o;
  logic [15:0] sig_writes_o;
  logic        t_done, t_pass, t_fail, t_timeout;
  logic [31:0] t_code, t_cycles;
  logic [15:0] t_sig;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_monitor dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
    .dmem_addr_i(addr), .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata),
    .trap_i(trap), .gp_i(gp), .a7_i(a7), .a0_i(a0),
    .sig_begin_i(sig_b), .sig_end_i(sig_e),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .fail_code_o(fail_code_o), .cycles_o(cycles_o), .sig_writes_o(sig_writes_o)
  );

  test_monitor #(.MAX_TICKS(20)) dut_t (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
    .dmem_addr_i(addr), .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata),
    .trap_i(trap), .gp_i(gp), .a7_i(a7), .a0_i(a0),
    .sig_begin_i(sig_b), .sig_end_i(sig_e),
    .done_o(t_done), .pass_o(t_pass), .fail_o(t_fail), .timeout_o(t_timeout),
    .fail_code_o(t_code), .cycles_o(t_cycles), .sig_writes_o(t_sig)
  );

  // One cycle of stimulus plus the outputs required after the edge.
  // flags = {done, pass, fail, timeout}
  typedef struct {
    string       name;
    logic [3:0]  flags;
    logic [31:0] cyc;
    logic [15:0] sig;
    logic        chk;
    logic [31:0] code;
    logic        en;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  wsel;
    logic [31:0] addr, data;
    logic        trap;
    logic [31:0] gp, a7, a0;
    logic [31:0] rbeg, rend;
  } step_t;

  step_t sb[$];

  function automatic step_t mk(string name, logic [3:0] flags, logic [31:0] cyc,
                               logic [15:0] sig, logic chk, logic [31:0] code,
                               logic en, logic [1:0] mode,
                               logic [3:0] w = 4'h0, logic [31:0] ad = 32'h0,
                               logic [31:0] d = 32'h0, logic tr = 1'b0,
                               logic [31:0] g = 32'h0, logic [31:0] r7 = 32'h0,
                               logic [31:0] r0 = 32'h0, logic r = 1'b0);
    step_t s;
    s.name = name; s.flags = flags; s.cyc = cyc; s.sig = sig; s.chk = chk;
    s.code = code; s.en = en; s.rst = r; s.mode = mode; s.wsel = w;
    s.addr = ad; s.data = d; s.trap = tr; s.gp = g; s.a7 = r7; s.a0 = r0;
    s.rbeg = SIG_B; s.rend = SIG_E;
    return s;
  endfunction

  task automatic apply(input step_t s);
    en = s.en; rst = s.rst; mode = s.mode; wsel = s.wsel; addr = s.addr;
    wdata = s.data; trap = s.trap; gp = s.gp; a7 = s.a7; a0 = s.a0;
    sig_b = s.rbeg; sig_e = s.rend;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t e;
    sb.push_back(mk("reset", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd0, 4'hF, TOHOST, 1, 0, 0, 0, 0, 1'b1));
    apply(sb[$]);
    tick();
    e = sb.pop_front();
    checks++;
    if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc ||
        sig_writes_o !== e.sig || fail_code_o !== e.code) begin
      errors++;
      $display("FAIL %s: got flags=%b cyc=%0d sig=%0d code=%h, want flags=%b cyc=%0d sig=%0d code=%h",
               e.name, {done_o, pass_o, fail_o, timeout_o}, cycles_o, sig_writes_o,
               fail_code_o, e.flags, e.cyc, e.sig, e.code);
    end
    checks++;
    if ({t_done, t_pass, t_fail, t_timeout} !== 4'b0000 || t_cycles !== 32'd0 ||
        t_sig !== 16'd0 || t_code !== 32'd0) begin
      errors++;
      $display("FAIL reset_t: got flags=%b cyc=%0d sig=%0d code=%h, want all zero",
               {t_done, t_pass, t_fail, t_timeout}, t_cycles, t_sig, t_code);
    end
  endtask

  task automatic test_tohost_pass();
    step_t q[$];
    step_t e;
    q.push_back(mk("tp_idle", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd0));
    q.push_back(mk("tp_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    for (int j = 1; j <= 50; j++) q.push_back(mk("tp_run", 4'b0000, j, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("tp_pass", 4'b1100, 51, 0, 0, 0, 1'b1, 2'd0, 4'hF, TOHOST, 32'h1));
    q.push_back(mk("tp_frozen", 4'b1100, 51, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("tp_frozen2", 4'b1100, 51, 0, 0, 0, 1'b1, 2'd0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc ||
          sig_writes_o !== e.sig) begin
        errors++;
        $display("FAIL %s[%0d]: got flags=%b cyc=%0d sig=%0d, want flags=%b cyc=%0d sig=%0d",
                 e.name, i, {done_o, pass_o, fail_o, timeout_o}, cycles_o, sig_writes_o,
                 e.flags, e.cyc, e.sig);
      end
    end
  endtask

  task automatic test_tohost_fail();
    step_t q[$];
    step_t e;
    q.push_back(mk("tf_idle", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd0));
    q.push_back(mk("tf_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("tf_trap_ignored", 4'b0000, 1, 0, 0, 0, 1'b1, 2'd0, 4'h0, 0, 0, 1'b1, 1, 93, 0));
    q.push_back(mk("tf_clear", 4'b0000, 2, 0, 0, 0, 1'b1, 2'd0, 4'hF, TOHOST, 32'h0));
    q.push_back(mk("tf_fail7", 4'b1010, 3, 0, 1, 3, 1'b1, 2'd0, 4'hF, TOHOST, 32'h7));
    q.push_back(mk("tf_partial", 4'b1010, 3, 0, 1, 3, 1'b1, 2'd0, 4'h1, TOHOST, 32'h1));
    q.push_back(mk("tf_sticky", 4'b1010, 3, 0, 1, 3, 1'b1, 2'd0, 4'hF, TOHOST, 32'h1));
    q.push_back(mk("tf_drop", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd0));
    q.push_back(mk("tf_arm2", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("tf_partial_run", 4'b0000, 1, 0, 0, 0, 1'b1, 2'd0, 4'h7, TOHOST, 32'h1));
    q.push_back(mk("tf_even", 4'b1010, 2, 0, 1, 32'hFFFF_FFFF, 1'b1, 2'd0, 4'hF, TOHOST, 32'h2));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc) begin
        errors++;
        $display("FAIL %s: got flags=%b cyc=%0d, want flags=%b cyc=%0d",
                 e.name, {done_o, pass_o, fail_o, timeout_o}, cycles_o, e.flags, e.cyc);
      end
      if (e.chk) begin
        checks++;
        if (fail_code_o !== e.code) begin
          errors++;
          $display("FAIL %s code: got %h, want %h", e.name, fail_code_o, e.code);
        end
      end
    end
  endtask

  task automatic test_trap();
    step_t q[$];
    step_t e;
    q.push_back(mk("tr_idle", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd1));
    q.push_back(mk("tr_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd1));
    q.push_back(mk("tr_pass", 4'b1100, 1, 0, 0, 0, 1'b1, 2'd1, 4'h0, 0, 0, 1'b1, 1, 93, 0));
    q.push_back(mk("tr_drop", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd1));
    q.push_back(mk("tr_arm2", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd1));
    q.push_back(mk("tr_tohost_ignored", 4'b0000, 1, 0, 0, 0, 1'b1, 2'd1, 4'hF, TOHOST, 32'h1));
    q.push_back(mk("tr_a7_10", 4'b0000, 2, 0, 0, 0, 1'b1, 2'd1, 4'h0, 0, 0, 1'b1, 1, 10, 11));
    q.push_back(mk("tr_gp0_a0_0", 4'b0000, 3, 0, 0, 0, 1'b1, 2'd1, 4'h0, 0, 0, 1'b1, 0, 93, 0));
    q.push_back(mk("tr_no_trap", 4'b0000, 4, 0, 0, 0, 1'b1, 2'd1, 4'h0, 0, 0, 1'b0, 1, 93, 11));
    q.push_back(mk("tr_fail11", 4'b1010, 5, 0, 1, 5, 1'b1, 2'd1, 4'h0, 0, 0, 1'b1, 1, 93, 11));
    q.push_back(mk("tr_sticky", 4'b1010, 5, 0, 1, 5, 1'b1, 2'd1, 4'h0, 0, 0, 1'b1, 1, 93, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc) begin
        errors++;
        $display("FAIL %s: got flags=%b cyc=%0d, want flags=%b cyc=%0d",
                 e.name, {done_o, pass_o, fail_o, timeout_o}, cycles_o, e.flags, e.cyc);
      end
      if (e.chk) begin
        checks++;
        if (fail_code_o !== e.code) begin
          errors++;
          $display("FAIL %s code: got %h, want %h", e.name, fail_code_o, e.code);
        end
      end
    end
  endtask

  task automatic test_both();
    step_t q[$];
    step_t e;
    q.push_back(mk("bo_idle", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd2));
    q.push_back(mk("bo_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd2));
    q.push_back(mk("bo_tohost_wins", 4'b1100, 1, 0, 0, 0, 1'b1, 2'd2, 4'hF, TOHOST, 32'h1, 1'b1, 1, 93, 9));
    q.push_back(mk("bo_drop", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd3));
    q.push_back(mk("bo_arm3", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd3));
    q.push_back(mk("bo_m3_trap", 4'b1010, 1, 0, 1, 4, 1'b1, 2'd3, 4'h0, 0, 0, 1'b1, 1, 93, 9));
    q.push_back(mk("bo_drop2", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd3));
    q.push_back(mk("bo_arm3b", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd3));
    q.push_back(mk("bo_m3_tohost", 4'b1010, 1, 0, 1, 2, 1'b1, 2'd3, 4'hF, TOHOST, 32'h5));
    q.push_back(mk("bo_drop3", 4'b0000, 0, 0, 1, 0, 1'b0, 2'd2));
    q.push_back(mk("bo_arm2", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd2));
    q.push_back(mk("bo_fail_wins", 4'b1010, 1, 0, 1, 3, 1'b1, 2'd2, 4'hF, TOHOST, 32'h7, 1'b1, 1, 93, 0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc) begin
        errors++;
        $display("FAIL %s: got flags=%b cyc=%0d, want flags=%b cyc=%0d",
                 e.name, {done_o, pass_o, fail_o, timeout_o}, cycles_o, e.flags, e.cyc);
      end
      if (e.chk) begin
        checks++;
        if (fail_code_o !== e.code) begin
          errors++;
          $display("FAIL %s code: got %h, want %h", e.name, fail_code_o, e.code);
        end
      end
    end
  endtask

  // Uses the MAX_TICKS = 20 instance.
  task automatic test_timeout();
    step_t q[$];
    step_t e;
    q.push_back(mk("to_idle", 4'b0000, 0, 0, 0, 0, 1'b0, 2'd0));
    q.push_back(mk("to_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    for (int j = 1; j <= 19; j++) q.push_back(mk("to_run", 4'b0000, j, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("to_expire", 4'b1001, 20, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("to_hold", 4'b1001, 20, 0, 0, 0, 1'b1, 2'd0, 4'hF, TOHOST, 32'h1));
    q.push_back(mk("to_drop", 4'b0000, 0, 0, 0, 0, 1'b0, 2'd0));
    q.push_back(mk("to_arm2", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    for (int j = 1; j <= 19; j++) q.push_back(mk("to_run2", 4'b0000, j, 0, 0, 0, 1'b1, 2'd0));
    q.push_back(mk("to_pass_last", 4'b1100, 20, 0, 0, 0, 1'b1, 2'd0, 4'hF, TOHOST, 32'h1));
    q.push_back(mk("to_pass_hold", 4'b1100, 20, 0, 0, 0, 1'b1, 2'd0));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({t_done, t_pass, t_fail, t_timeout} !== e.flags || t_cycles !== e.cyc) begin
        errors++;
        $display("FAIL %s[%0d]: got flags=%b cyc=%0d, want flags=%b cyc=%0d",
                 e.name, i, {t_done, t_pass, t_fail, t_timeout}, t_cycles, e.flags, e.cyc);
      end
    end
  endtask

  task automatic test_sig();
    step_t q[$];
    step_t s;
    step_t e;
    q.push_back(mk("sg_idle", 4'b0000, 0, 0, 0, 0, 1'b0, 2'd0));
    q.push_back(mk("sg_arm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0));
    s = mk("sg_empty_region", 4'b0000, 1, 0, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B);
    s.rend = SIG_B;
    q.push_back(s);
    q.push_back(mk("sg_begin", 4'b0000, 2, 1, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B));
    q.push_back(mk("sg_last", 4'b0000, 3, 2, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B + 32'hC));
    q.push_back(mk("sg_end", 4'b0000, 4, 2, 0, 0, 1'b1, 2'd0, 4'hF, SIG_E));
    q.push_back(mk("sg_below", 4'b0000, 5, 2, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B - 32'h4));
    q.push_back(mk("sg_no_wsel", 4'b0000, 6, 2, 0, 0, 1'b1, 2'd0, 4'h0, SIG_B + 32'h4));
    q.push_back(mk("sg_byte", 4'b0000, 7, 3, 0, 0, 1'b1, 2'd0, 4'h2, SIG_B + 32'h8));
    q.push_back(mk("sg_reset", 4'b0000, 0, 0, 1, 0, 1'b1, 2'd0, 4'hF, SIG_B, 0, 0, 0, 0, 0, 1'b1));
    q.push_back(mk("sg_rearm", 4'b0000, 0, 0, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B));
    q.push_back(mk("sg_after", 4'b0000, 1, 1, 0, 0, 1'b1, 2'd0, 4'hF, SIG_B));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({done_o, pass_o, fail_o, timeout_o} !== e.flags || cycles_o !== e.cyc ||
          sig_writes_o !== e.sig) begin
        errors++;
        $display("FAIL %s: got flags=%b cyc=%0d sig=%0d, want flags=%b cyc=%0d sig=%0d",
                 e.name, {done_o, pass_o, fail_o, timeout_o}, cycles_o, sig_writes_o,
                 e.flags, e.cyc, e.sig);
      end
      if (e.chk) begin
        checks++;
        if (fail_code_o !== e.code) begin
          errors++;
          $display("FAIL %s code: got %h, want %h", e.name, fail_code_o, e.code);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; wsel = 4'h0; addr = 32'h0; wdata = 32'h0;
    trap = 1'b0; gp = 32'h0; a7 = 32'h0; a0 = 32'h0; sig_b = SIG_B; sig_e = SIG_E;
    test_reset();
    test_tohost_pass();
    test_tohost_fail();
    test_trap();
    test_both();
    test_timeout();
    test_sig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
